// File: rtl/fft256_pkg.sv
// fft256_pkg: shared FFT size constants, bit-reverse helper and reorder reader state encoding
package fft256_pkg;
  localparam int FFT_N = 256;
  localparam int FFT_LOG2N = 8;
  typedef enum logic {IDLE, READ} rd_state_t;
  function automatic logic [FFT_LOG2N-1:0] bitrev8(input logic [FFT_LOG2N-1:0] a);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) r[i] = a[FFT_LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: 2x256-entry simple dual-port RAM, address {bank, addr}, one-cycle registered read
module fft_reorder_ram
  import fft256_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = FFT_LOG2N + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // write port; storage itself is never cleared
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  // registered read port; the output register clears on reset so downstream data starts at zero
  always_ff @(posedge clock or negedge reset)
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft256_bitrev_reorder.sv
// fft256_bitrev_reorder: ping-pong reorder of bit-reversed FFT output into natural bin order; FFT_REORDER_SOF_EN adds do_sof
module fft256_bitrev_reorder
  import fft256_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx
`ifdef FFT_REORDER_SOF_EN
  ,
  output logic             do_sof
`endif
);
  logic [LOG2N-1:0] wcount, rcount;
  logic wbank, rbank, wr_last, rd_last, rd_issue, chain;
  logic [1:0] full, set_m, clr_m;
  rd_state_t state, state_nx;
  logic [2*WIDTH-1:0] rdata;
  assign wr_last = di_en && (wcount == '1);
  assign rd_last = rd_issue && (rcount == '1);
  assign set_m = {wr_last & wbank, wr_last & ~wbank};
  assign clr_m = {rd_last & rbank, rd_last & ~rbank};
  assign chain = full[~rbank] || (wr_last && (wbank != rbank));
  assign {do_re, do_im} = rdata;
  // writer: count arrivals, restart on any gap, flip bank after a complete frame
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wcount <= '0;
      wbank <= 1'b0;
    end else begin
      wcount <= di_en ? wcount + 1'b1 : '0;
      if (wr_last) wbank <= ~wbank;
    end
  // bank-full flags: set by writer completion, cleared by reader completion, both may land together
  always_ff @(posedge clock or negedge reset)
    if (!reset) full <= 2'b00;
    else full <= (full | set_m) & ~clr_m;
  // reader state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // reader next state: chain straight into the other bank when it is already (or just became) full
  always_comb
    state_nx = (state == IDLE) ? (full[rbank] ? READ : IDLE) : ((rd_last && !chain) ? IDLE : READ);
  // reader outputs: a read is issued every cycle spent in READ
  always_comb
    rd_issue = (state == READ);
  // reader address and bank tracking
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rcount <= '0;
      rbank <= 1'b0;
    end else begin
      rcount <= rd_issue ? rcount + 1'b1 : '0;
      if (rd_last) rbank <= ~rbank;
    end
  fft_reorder_ram #(.DW(2*WIDTH), .AW(LOG2N+1)) u_ram (
    .clock(clock),
    .reset(reset),
    .we(di_en),
    .waddr({wbank, bitrev8(wcount)}),
    .wdata({di_re, di_im}),
    .re(rd_issue),
    .raddr({rbank, rcount}),
    .rdata(rdata)
  );
  // output qualifiers aligned with the registered RAM read; index holds while idle
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      do_en <= 1'b0;
      do_idx <= '0;
`ifdef FFT_REORDER_SOF_EN
      do_sof <= 1'b0;
`endif
    end else begin
      do_en <= rd_issue;
      if (rd_issue) do_idx <= rcount;
`ifdef FFT_REORDER_SOF_EN
      do_sof <= rd_issue && (rcount == '0);
`endif
    end
`ifndef SYNTHESIS
  // overrun guard: a new frame must never start on a bank still awaiting readout
  always_ff @(posedge clock)
    if (reset && di_en && (wcount == '0))
      assert (!full[wbank] || (rd_last && (rbank == wbank)))
      else $error("reorder overrun on bank %0d", wbank);
`endif
endmodule

// File: tb/tb_fft256_bitrev_reorder.sv
// tb_fft256_bitrev_reorder: randomized scoreboard bench for the natural-order reorder stage
module tb_fft256_bitrev_reorder;
  logic clock = 1'b0, reset = 1'b0, di_en = 1'b0;
  logic [15:0] di_re = '0, di_im = '0;
  logic do_en;
  logic [15:0] do_re, do_im;
  logic [7:0] do_idx;
`ifdef FFT_REORDER_SOF_EN
  logic do_sof;
  int sofs = 0;
`endif
  int checks = 0, passes = 0, cyc = 0, run = 0;
  logic [15:0] fr_re [256];
  logic [15:0] fr_im [256];
  typedef struct {int t; int idx; logic [15:0] re; logic [15:0] im;} exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fft256_bitrev_reorder dut (
    .clock(clock),
    .reset(reset),
    .di_en(di_en),
    .di_re(di_re),
    .di_im(di_im),
    .do_en(do_en),
    .do_re(do_re),
    .do_im(do_im),
    .do_idx(do_idx)
`ifdef FFT_REORDER_SOF_EN
    ,
    .do_sof(do_sof)
`endif
  );

  function automatic int rev(int x);
    int r = 0;
    for (int i = 0; i < 8; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // one input sample; a completed run of 256 yields the natural-order frame 2 edges after its last write
  task automatic put(input logic [15:0] re, input logic [15:0] im);
    @(negedge clock);
    di_en = 1'b1;
    di_re = re;
    di_im = im;
    fr_re[run] = re;
    fr_im[run] = im;
    run++;
    if (run == 256) begin
      for (int n = 0; n < 256; n++) sb.push_back('{cyc + 3 + n, n, fr_re[rev(n)], fr_im[rev(n)]});
      run = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      di_en = 1'b0;
      di_re = 16'($urandom);
      di_im = 16'($urandom);
      run = 0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(posedge clock);
      w++;
    end
    chk("drain", sb.size(), 0);
    idle(4);
  endtask

  // monitor: every presented output must match the head of the scoreboard, including its cycle
  initial forever begin
    @(posedge clock);
    #1;
    if (reset && do_en) begin
      chk("out_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("out_n%0d", e.idx), {16'(cyc), do_idx, do_re, do_im},
            {16'(e.t), 8'(e.idx), e.re, e.im});
      end
`ifdef FFT_REORDER_SOF_EN
      chk("sof_align", do_sof, do_idx == 8'd0);
      if (do_sof) sofs++;
`endif
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, bad;
    repeat (3) @(negedge clock);
    chk("rst_do_en", do_en, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    chk("rst_do_idx", do_idx, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    for (int k = 0; k < 256; k++) put(16'(k), 16'(255 - k));
    idle(3);
    drain();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 256; k++) put(16'($urandom), {8'(f), 8'($urandom)});
    idle(1);
    drain();
    for (int k = 0; k < 100; k++) put(16'($urandom), 16'($urandom));
    idle(5);
    for (int k = 0; k < 256; k++) put(16'($urandom), 16'($urandom));
    idle(1);
    drain();
    for (int k = 0; k < 256; k++) put((k == 1) ? 16'h7FFF : 16'h0000, 16'h0000);
    idle(1);
    drain();
    for (int k = 0; k < 256; k++) put(16'($urandom), 16'($urandom));
    idle(10);
    for (int k = 0; k < 256; k++) put(16'($urandom), 16'($urandom));
    idle(1);
    drain();
`ifdef FFT_REORDER_SOF_EN
    chk("sof_count", sofs, 8);
`endif
    for (int k = 0; k < 256; k++) put(16'($urandom), 16'($urandom));
    idle(1);
    w = 0;
    do begin
      @(posedge clock);
      #1;
      w++;
    end while (!(do_en && do_idx == 8'd50) && w < 1000);
    chk("reach_idx50", w < 1000, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_do_en", do_en, 0);
    chk("async_rst_do_re", do_re, 0);
    chk("async_rst_do_im", do_im, 0);
    chk("async_rst_do_idx", do_idx, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(posedge clock);
      #1;
      if (do_en) bad++;
    end
    chk("idle_after_reset", bad, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
